fmul_share_arb: RTL and testbench

//  Shares one fmul_for_fdiv_300 instance (fixed latency, fully pipelined, no stall) between two

---
 rtl/fmul_share_arb.sv | 135 +++++++++++++
 tb/tb_fmul_share_arb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : fmul_share_arb
// Brief    : Round-robin sharing of one fixed-latency pipelined fmul between
//            two requesters, with per-op tracking to route results back.
// Revision : 1.0
// ============================================================================
module fmul_share_arb #(
  parameter int LAT = 2,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [31:0]   req0_x1,
  input  logic [31:0]   req0_x2,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [31:0]   req1_x1,
  input  logic [31:0]   req1_x2,
  output logic [31:0]   mul_x1,
  output logic [31:0]   mul_x2,
  input  logic [31:0]   mul_y,
  output logic          rsp0_valid,
  output logic [31:0]   rsp0_y,
  output logic          rsp1_valid,
  output logic [31:0]   rsp1_y,
  output logic [CW-1:0] inflight
);

  // ptr_q = 0 gives requester 0 priority when both are valid
  logic          ptr_q,      ptr_d;
  logic [LAT:0]  trk_v_q,    trk_v_d;
  logic [LAT:0]  trk_id_q,   trk_id_d;
  logic [31:0]   mul_x1_q,   mul_x1_d;
  logic [31:0]   mul_x2_q,   mul_x2_d;
  logic          rsp0_v_q,   rsp0_v_d;
  logic          rsp1_v_q,   rsp1_v_d;
  logic [31:0]   rsp0_y_q,   rsp0_y_d;
  logic [31:0]   rsp1_y_q,   rsp1_y_d;
  logic [CW-1:0] inflight_q, inflight_d;

  logic grant0;
  logic grant1;
  logic grant_any;
  logic ret;
  logic ret_id;

  // Ready is forced low during reset so nothing is handshaken while state is held
  assign grant0    = rstn & req0_valid & (~req1_valid | ~ptr_q);
  assign grant1    = rstn & req1_valid & (~req0_valid |  ptr_q);
  assign grant_any = grant0 | grant1;

  // The oldest tracker stage is aligned with mul_y for the op it describes
  assign ret    = trk_v_q[LAT];
  assign ret_id = trk_id_q[LAT];

  always_comb begin
    ptr_d      = ptr_q;
    mul_x1_d   = mul_x1_q;
    mul_x2_d   = mul_x2_q;
    trk_v_d    = {trk_v_q[LAT-1:0],  grant_any};
    trk_id_d   = {trk_id_q[LAT-1:0], grant1};
    rsp0_v_d   = ret & ~ret_id;
    rsp1_v_d   = ret &  ret_id;
    rsp0_y_d   = rsp0_y_q;
    rsp1_y_d   = rsp1_y_q;
    inflight_d = inflight_q;

    if (grant0) begin
      ptr_d    = 1'b1;
      mul_x1_d = req0_x1;
      mul_x2_d = req0_x2;
    end else if (grant1) begin
      ptr_d    = 1'b0;
      mul_x1_d = req1_x1;
      mul_x2_d = req1_x2;
    end

    if (rsp0_v_d) rsp0_y_d = mul_y;
    if (rsp1_v_d) rsp1_y_d = mul_y;

    case ({grant_any, ret})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= 1'b0;
      trk_v_q    <= '0;
      trk_id_q   <= '0;
      mul_x1_q   <= '0;
      mul_x2_q   <= '0;
      rsp0_v_q   <= 1'b0;
      rsp1_v_q   <= 1'b0;
      rsp0_y_q   <= '0;
      rsp1_y_q   <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      trk_v_q    <= trk_v_d;
      trk_id_q   <= trk_id_d;
      mul_x1_q   <= mul_x1_d;
      mul_x2_q   <= mul_x2_d;
      rsp0_v_q   <= rsp0_v_d;
      rsp1_v_q   <= rsp1_v_d;
      rsp0_y_q   <= rsp0_y_d;
      rsp1_y_q   <= rsp1_y_d;
      inflight_q <= inflight_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mul_x1     = mul_x1_q;
  assign mul_x2     = mul_x2_q;
  assign rsp0_valid = rsp0_v_q;
  assign rsp1_valid = rsp1_v_q;
  assign rsp0_y     = rsp0_y_q;
  assign rsp1_y     = rsp1_y_q;
  assign inflight   = inflight_q;

  a_one_grant: assert property (@(posedge clk) disable iff (!rstn)
    !(req0_ready && req1_ready));
  a_inflight_max: assert property (@(posedge clk) disable iff (!rstn)
    inflight <= CW'(LAT + 1));
  a_one_rsp: assert property (@(posedge clk) disable iff (!rstn)
    !(rsp0_valid && rsp1_valid));

endmodule
`default_nettype wire

// File: tb/tb_fmul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_share_arb
// Brief    : Directed and randomized bench for fmul_share_arb with an attached
//            pipelined fmul stub and a queue-based response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fmul_share_arb;

  localparam int LAT = 2;
  localparam int CW  = 3;

  logic          clk;
  logic          rstn;
  logic          v0, v1;
  logic [31:0]   a0, b0, a1, b1;
  logic          req0_ready, req1_ready;
  logic [31:0]   mul_x1, mul_x2, mul_y;
  logic          rsp0_valid, rsp1_valid;
  logic [31:0]   rsp0_y, rsp1_y;
  logic [CW-1:0] inflight;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  fmul_share_arb #(.LAT(LAT), .CW(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (v0),
    .req0_ready (req0_ready),
    .req0_x1    (a0),
    .req0_x2    (b0),
    .req1_valid (v1),
    .req1_ready (req1_ready),
    .req1_x1    (a1),
    .req1_x2    (b1),
    .mul_x1     (mul_x1),
    .mul_x2     (mul_x2),
    .mul_y      (mul_y),
    .rsp0_valid (rsp0_valid),
    .rsp0_y     (rsp0_y),
    .rsp1_valid (rsp1_valid),
    .rsp1_y     (rsp1_y),
    .inflight   (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Truncating single-precision multiply; denormals flush to zero
  function automatic logic [31:0] fmul_ref(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
    if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {s, 31'd0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  // Attached multiplier: LAT register stages behind mul_x*
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fmul_ref(mul_x1, mul_x2);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mul_y = pipe[LAT-1];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          id;
    logic [31:0] y;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  bit          last_id = 1'b1;
  logic [31:0] exp_y0 = '0, exp_y1 = '0;
  logic [31:0] cur_x1 = '0, cur_x2 = '0, nxt_x1 = '0, nxt_x2 = '0;
  int          wait0 = 0, wait1 = 0;

  always @(negedge clk) begin
    bit   e0, e1, g0, g1;
    rsp_t r;
    if (!rstn) begin
      sb.delete();
      last_id = 1'b1;
      exp_y0 = '0; exp_y1 = '0;
      cur_x1 = '0; cur_x2 = '0; nxt_x1 = '0; nxt_x2 = '0;
      wait0 = 0; wait1 = 0;
      chk1 ("rst_rdy0", req0_ready, 1'b0);
      chk1 ("rst_rdy1", req1_ready, 1'b0);
      chk1 ("rst_rv0",  rsp0_valid, 1'b0);
      chk1 ("rst_rv1",  rsp1_valid, 1'b0);
      chk32("rst_y0",   rsp0_y, 32'd0);
      chk32("rst_y1",   rsp1_y, 32'd0);
      chk32("rst_mx1",  mul_x1, 32'd0);
      chk32("rst_mx2",  mul_x2, 32'd0);
      chk32("rst_infl", 32'(inflight), 32'd0);
    end else begin
      cur_x1 = nxt_x1;
      cur_x2 = nxt_x2;
      e0 = 1'b0;
      e1 = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        r = sb.pop_front();
        if (r.id) begin e1 = 1'b1; exp_y1 = r.y; end
        else      begin e0 = 1'b1; exp_y0 = r.y; end
      end
      chk1 ("rsp0_valid", rsp0_valid, e0);
      chk1 ("rsp1_valid", rsp1_valid, e1);
      chk32("rsp0_y",     rsp0_y, exp_y0);
      chk32("rsp1_y",     rsp1_y, exp_y1);
      chk32("inflight",   32'(inflight), 32'(sb.size()));
      chk32("mul_x1",     mul_x1, cur_x1);
      chk32("mul_x2",     mul_x2, cur_x2);

      // Both waiting: the side not served last wins
      if (v0 && v1) begin
        g0 = (last_id == 1'b1);
        g1 = !g0;
      end else begin
        g0 = v0;
        g1 = v1;
      end
      chk1("req0_ready", req0_ready, g0);
      chk1("req1_ready", req1_ready, g1);

      if (g0 || g1) begin
        r.id  = g1;
        r.y   = g1 ? fmul_ref(a1, b1) : fmul_ref(a0, b0);
        r.due = cyc + LAT + 2;
        sb.push_back(r);
        nxt_x1  = g1 ? a1 : a0;
        nxt_x2  = g1 ? b1 : b0;
        last_id = g1;
      end

      wait0 = (v0 && !req0_ready) ? wait0 + 1 : 0;
      wait1 = (v1 && !req1_ready) ? wait1 + 1 : 0;
      chk1("starve0", wait0 > 1, 1'b0);
      chk1("starve1", wait1 > 1, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic nv0, input logic nv1,
                      input logic [31:0] na0, input logic [31:0] nb0,
                      input logic [31:0] na1, input logic [31:0] nb1);
    @(posedge clk);
    #1;
    v0 = nv0; v1 = nv1;
    a0 = na0; b0 = nb0; a1 = na1; b1 = nb1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rnd_f();
    logic [7:0] e;
    case ($urandom_range(0, 15))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom())};
  endfunction

  logic [31:0] t4a [4] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h3F000000};
  logic [31:0] t4b [4] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h40800000};
  logic [31:0] t4p [4] = '{32'h40000000, 32'h40C00000, 32'h40100000, 32'h40000000};

  initial begin
    rstn = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    a0 = 32'h3F800000; b0 = 32'h3F800000;
    a1 = 32'h40000000; b1 = 32'h40000000;

    // Hand-computed products pin the reference multiply
    chk32("ref_1p5x1",  fmul_ref(a0 ^ 32'h00400000, b0), 32'h3FC00000);
    chk32("ref_1p5x0p5", fmul_ref(32'h3FC00000, 32'h3F000000), 32'h3F400000);
    chk32("ref_2x3",    fmul_ref(a1, 32'h40400000), 32'h40C00000);

    // Reset with both valid, then release: requester 0 first
    repeat (3) @(negedge clk);
    chk1("t1_rdy0_rst", req0_ready, 1'b0);
    chk1("t1_rdy1_rst", req1_ready, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk1("t1_rdy0_first", req0_ready, 1'b1);
    chk1("t1_rdy1_first", req1_ready, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 32'd0, 32'd0, 32'h3F800000, 32'h3F800000);
    idle(6);

    // Requester 1 alone for 4 cycles, pointer at 0
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'd0, 32'd0, t4a[i], t4b[i]);
      @(negedge clk);
      chk1("t4_rdy1", req1_ready, 1'b1);
    end
    idle(1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1 ("t4_rv1", rsp1_valid, 1'b1);
      chk32("t4_y1",  rsp1_y, t4p[k]);
    end
    idle(4);

    // Both valid for 6 cycles: strict alternation starting with 0
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, rnd_f(), rnd_f(), rnd_f(), rnd_f());
      @(negedge clk);
      chk1("t3_rdy0", req0_ready, i[0] == 1'b0);
      chk1("t3_rdy1", req1_ready, i[0] == 1'b1);
      if (i == 3) chk32("t3_peak", 32'(inflight), 32'd3);
      if (i >= 4) begin
        chk1("t3_rv0", rsp0_valid, i[0] == 1'b0);
        chk1("t3_rv1", rsp1_valid, i[0] == 1'b1);
      end
    end
    idle(1);
    for (int k = 2; k < 6; k++) begin
      if (k > 2) @(posedge clk);
      @(negedge clk);
      chk1("t3_rv0_tail", rsp0_valid, k[0] == 1'b0);
      chk1("t3_rv1_tail", rsp1_valid, k[0] == 1'b1);
    end
    idle(3);

    // Single op on requester 0: 1.5 * 1.0, then 1.5 * 0.5
    for (int j = 0; j < 2; j++) begin
      step(1'b1, 1'b0, 32'h3FC00000, (j == 0) ? 32'h3F800000 : 32'h3F000000, 32'd0, 32'd0);
      @(negedge clk);
      chk1("t2_rdy0", req0_ready, 1'b1);
      idle(1);
      @(negedge clk);
      chk32("t2_infl1", 32'(inflight), 32'd1);
      repeat (2) begin
        @(negedge clk);
        chk1("t2_rv0_early", rsp0_valid, 1'b0);
      end
      @(negedge clk);
      chk1 ("t2_rv0",    rsp0_valid, 1'b1);
      chk32("t2_y0",     rsp0_y, (j == 0) ? 32'h3FC00000 : 32'h3F400000);
      chk1 ("t2_rv1",    rsp1_valid, 1'b0);
      chk32("t2_infl0",  32'(inflight), 32'd0);
      idle(2);
    end

    // Reset while two ops are in flight drops them
    step(1'b1, 1'b0, 32'h40000000, 32'h40000000, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'h40400000, 32'h40000000, 32'd0, 32'd0);
    idle(1);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk1 ("t5_rv0",  rsp0_valid, 1'b0);
      chk1 ("t5_rv1",  rsp1_valid, 1'b0);
      chk32("t5_infl", 32'(inflight), 32'd0);
    end
    step(1'b0, 1'b1, 32'd0, 32'd0, 32'h40400000, 32'h40400000);
    idle(1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk1 ("t5_rv1_after", rsp1_valid, 1'b1);
    chk32("t5_y1_after",  rsp1_y, 32'h41100000);
    idle(3);

    // Randomized traffic with varying request density
    for (int n = 0; n < 10000; n++) begin
      int dens;
      dens = (n / 1000) % 4;
      step(1'($urandom_range(0, 3) < dens + 1), 1'($urandom_range(0, 3) < 4 - dens),
           rnd_f(), rnd_f(), rnd_f(), rnd_f());
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
